// File: rtl/idct4x4_seq_pkg.sv
// Shared definitions for the sequenced 4x4 inverse transform: sample width,
// core normalisation shift and the FSM state encoding.
package idct4x4_seq_pkg;
    localparam int WIDTH = 8;
    localparam int SHIFT = 2;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        COL  = 2'd1,
        OUT  = 2'd2
    } state_e;
endpackage

// File: rtl/idct4_core.sv
// Pure combinational 4-point inverse butterfly, evaluated at W+2 bits and
// normalised with an arithmetic (floor) shift, then truncated back to W bits.
module idct4_core
    import idct4x4_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [4*W-1:0] a,
    output logic [4*W-1:0] b
);
    localparam int IW = W + 2;

    logic signed [IW-1:0] a0, a1, a2, a3;
    logic signed [IW-1:0] t0, t1;
    logic signed [IW-1:0] s0, s1, s2, s3;

    assign a0 = IW'($signed(a[0*W +: W]));
    assign a1 = IW'($signed(a[1*W +: W]));
    assign a2 = IW'($signed(a[2*W +: W]));
    assign a3 = IW'($signed(a[3*W +: W]));

    assign t0 = a0 + a2;
    assign t1 = a0 - a2;

    // Worst-case sums stay within W+2 signed bits, so no wrap before the shift.
    assign s0 = t0 + (a1 <<< 1);
    assign s1 = t1 - (a3 <<< 1);
    assign s2 = t1 + (a3 <<< 1);
    assign s3 = t0 - (a1 <<< 1);

    assign b[0*W +: W] = W'(s0 >>> SHIFT);
    assign b[1*W +: W] = W'(s1 >>> SHIFT);
    assign b[2*W +: W] = W'(s2 >>> SHIFT);
    assign b[3*W +: W] = W'(s3 >>> SHIFT);
endmodule

// File: rtl/idct4x4_seq.sv
// 4x4 2-D inverse transform built around one shared butterfly: row pass on
// ingress, column pass in place in the transpose buffer, then row-wise egress.
module idct4x4_seq
    import idct4x4_seq_pkg::*;
#(
    parameter int WIDTH = idct4x4_seq_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [4*WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [4*WIDTH-1:0] m_data,
    output logic               m_last,
    output logic               busy
);
    // valid/ready: a beat transfers on a rising edge where valid & ready are both
    // high; a source holds valid and data stable until that edge.

    state_e             state;
    logic [1:0]         row_cnt, col_cnt, out_cnt;
    logic [WIDTH-1:0]   mem [0:3][0:3];
    logic [4*WIDTH-1:0] core_in, core_out;

    always_comb begin
        core_in = s_data;
        if (state == COL) begin
            for (int r = 0; r < 4; r++) core_in[r*WIDTH +: WIDTH] = mem[r][col_cnt];
        end
    end

    idct4_core #(.W(WIDTH)) u_core (
        .a (core_in),
        .b (core_out)
    );

    // Each column is read exactly once, so writing it back in place is safe.
    always_ff @(posedge clk) begin
        if (state == LOAD && s_valid && s_ready) begin
            for (int c = 0; c < 4; c++) mem[row_cnt][c] <= core_out[c*WIDTH +: WIDTH];
        end else if (state == COL) begin
            for (int r = 0; r < 4; r++) mem[r][col_cnt] <= core_out[r*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        m_data = '0;
        for (int c = 0; c < 4; c++) m_data[c*WIDTH +: WIDTH] = mem[out_cnt][c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            row_cnt <= 2'd0;
            col_cnt <= 2'd0;
            out_cnt <= 2'd0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            state   <= COL;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                COL: begin
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        out_cnt <= out_cnt + 2'd1;
                        m_last  <= (out_cnt == 2'd2);
                        if (out_cnt == 2'd3) begin
                            state   <= LOAD;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= LOAD;
                    row_cnt <= 2'd0;
                    col_cnt <= 2'd0;
                    out_cnt <= 2'd0;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_idct4x4_seq.sv
// Bench for idct4x4_seq: table vectors plus random blocks, stalls, gapped
// ingress, held ingress during busy, and reset in the middle of a block.
module tb_idct4x4_seq;
    localparam int W = 8;

    typedef struct {
        logic [4*W-1:0] rows [4];
        logic [4*W-1:0] exp_row;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid, s_ready;
    logic [4*W-1:0] s_data;
    logic           m_valid, m_ready;
    logic [4*W-1:0] m_data;
    logic           m_last, busy;

    int checks   = 0;
    int failures = 0;
    logic [4*W:0] exp_q [$];

    idct4x4_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [4*W-1:0] ref4(input logic [4*W-1:0] v);
        int a0, a1, a2, a3, t0, t1;
        int b [4];
        logic [4*W-1:0] r;
        a0 = int'($signed(v[7:0]));
        a1 = int'($signed(v[15:8]));
        a2 = int'($signed(v[23:16]));
        a3 = int'($signed(v[31:24]));
        t0 = a0 + a2;
        t1 = a0 - a2;
        b[0] = (t0 + 2 * a1) >>> 2;
        b[1] = (t1 - 2 * a3) >>> 2;
        b[2] = (t1 + 2 * a3) >>> 2;
        b[3] = (t0 - 2 * a1) >>> 2;
        for (int i = 0; i < 4; i++) r[i*W +: W] = b[i][W-1:0];
        return r;
    endfunction

    task automatic push_model(input logic [4*W-1:0] rows [4]);
        logic [4*W-1:0] p [4];
        logic [4*W-1:0] col, res;
        logic [4*W-1:0] o [4];
        for (int r = 0; r < 4; r++) p[r] = ref4(rows[r]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r*W +: W] = p[r][c*W +: W];
            res = ref4(col);
            for (int r = 0; r < 4; r++) o[r][c*W +: W] = res[r*W +: W];
        end
        for (int r = 0; r < 4; r++) exp_q.push_back({(r == 3), o[r]});
    endtask

    task automatic push_const(input logic [4*W-1:0] e);
        for (int r = 0; r < 4; r++) exp_q.push_back({(r == 3), e});
    endtask

    task automatic fail_msg(input string name, input logic [63:0] act, input logic [63:0] req);
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_block(input logic [4*W-1:0] rows [4], input bit gapped);
        int n;
        for (int r = 0; r < 4; r++) begin
            if (gapped && r > 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = rows[r];
            n = 0;
            while (!s_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!s_ready) begin
                checks++;
                fail_msg("ingress_timeout", 64'(r), 64'(4));
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    // Called right after the 4th accept: COL must already be running.
    task automatic check_latency();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0)
            fail_msg("col_entry", {61'd0, busy, s_ready, m_valid}, 64'b100);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (m_valid !== (i == 4) || s_ready !== 1'b0 || busy !== 1'b1)
                fail_msg("latency", {61'd0, m_valid, s_ready, busy}, {61'd0, (i == 4), 2'b01});
        end
    endtask

    task automatic recv_block(input int stall_row, input int stall_len, input bit rand_rdy);
        int got, cyc, left;
        got = 0; cyc = 0; left = stall_len;
        while (got < 4 && cyc < 200) begin
            if (m_valid && got == stall_row && left > 0) begin
                m_ready = 1'b0;
                left--;
            end else begin
                m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (m_valid && m_ready) got++;
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        checks++;
        if (got != 4) fail_msg("egress_timeout", 64'(got), 64'd4);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0)
            fail_msg("back_to_load", {61'd0, busy, s_ready, m_valid}, 64'b010);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [4*W-1:0] prev_data;
    logic           prev_last;
    bit             prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [4*W:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last)
                    fail_msg("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            end
            if (m_valid) begin
                checks++;
                if (s_ready !== 1'b0 || busy !== 1'b1)
                    fail_msg("out_flags", {62'd0, s_ready, busy}, 64'b01);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_row", {m_last, m_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) fail_msg("row_data", {m_last, m_data}, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t           vecs [4];
        logic [4*W-1:0] blk  [4];
        logic [4*W-1:0] blk2 [4];

        vecs[0].rows = '{32'h0000_0040, 32'h0, 32'h0, 32'h0}; vecs[0].exp_row = 32'h0404_0404;
        vecs[1].rows = '{32'h0000_0800, 32'h0, 32'h0, 32'h0}; vecs[1].exp_row = 32'hFF00_0001;
        vecs[2].rows = '{32'h0000_00FF, 32'h0, 32'h0, 32'h0}; vecs[2].exp_row = 32'hFFFF_FFFF;
        vecs[3].rows = '{32'h0004_0000, 32'h0, 32'h0, 32'h0}; vecs[3].exp_row = 32'h00FF_FF00;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0)
            fail_msg("reset_state", {60'd0, s_ready, m_valid, m_last, busy}, 64'b1000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors; m_ready high during LOAD must have no effect.
        for (int i = 0; i < 4; i++) begin
            push_const(vecs[i].exp_row);
            m_ready = 1'b1;
            send_block(vecs[i].rows, 1'b0);
            check_latency();
            recv_block(-1, 0, 1'b0);
        end

        // Gapped ingress gives the DC result and the same latency.
        push_const(vecs[0].exp_row);
        send_block(vecs[0].rows, 1'b1);
        check_latency();
        recv_block(-1, 0, 1'b0);

        // Random blocks with random egress readiness.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 4; r++) blk[r] = $urandom;
            push_model(blk);
            send_block(blk, 1'($urandom_range(0, 1)));
            check_latency();
            recv_block(-1, 0, 1'b1);
        end

        // Back-pressure: 5 stalled cycles on row 2 of a block with distinct rows.
        for (int r = 0; r < 4; r++) blk[r] = $urandom;
        push_model(blk);
        send_block(blk, 1'b0);
        check_latency();
        recv_block(2, 5, 1'b0);

        // Next block's first row held on s_valid through COL/OUT must not be lost.
        for (int r = 0; r < 4; r++) begin
            blk[r]  = $urandom;
            blk2[r] = $urandom;
        end
        push_model(blk);
        push_model(blk2);
        send_block(blk, 1'b0);
        s_valid = 1'b1;
        s_data  = blk2[0];
        check_latency();
        fork
            send_block(blk2, 1'b0);
            recv_block(-1, 0, 1'b1);
        join
        check_latency();
        recv_block(-1, 0, 1'b0);

        // Reset during COL discards the block; the following DC block is clean.
        for (int r = 0; r < 4; r++) blk[r] = $urandom;
        send_block(blk, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0)
            fail_msg("mid_reset_state", {60'd0, s_ready, m_valid, m_last, busy}, 64'b1000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_const(vecs[0].exp_row);
        send_block(vecs[0].rows, 1'b0);
        check_latency();
        recv_block(-1, 0, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) fail_msg("rows_missing", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: time %0t budget 500000", $time);
        $fatal(1, "timeout");
    end
endmodule
